// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer
// Sequences the 8086-mode 8259A interrupt-acknowledge protocol (two INTA
// pulses). It latches the acknowledged IR and drives the cascade lines in
// master role, decodes them against the slave ID in slave role, supplies
// the vector byte, and issues the ISR set and automatic-EOI pulses.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   inta_n       interrupt acknowledge (active low, synchronous to clk)
//   int_req      priority resolver has a pending unmasked IR
//   highest_ir   index of the highest-priority pending IR
//   sngl, sp_en  single-PIC mode / master (1) or slave (0) role
//   aeoi         automatic end-of-interrupt enable
//   icw2_base    vector base T7..T3
//   icw3         master: slave-present mask; slave: [2:0] slave ID
//   cas_in       sampled cascade lines
//   cas_out      cascade value driven in master role, cas_oe its enable
//   int_out      INT request to the CPU or master
//   isr_set      one-cycle pulse: set ISR bit isr_idx
//   isr_idx      IR index for isr_set / eoi_auto
//   eoi_auto     one-cycle pulse: clear ISR bit isr_idx
//   data_out     vector byte {icw2_base, ack_ir}, data_oe its enable
//   busy         INTA sequence in progress
module pic_inta_sequencer #(
  parameter int unsigned VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inta_n,
  input  logic             int_req,
  input  logic [2:0]       highest_ir,
  input  logic             sngl,
  input  logic             sp_en,
  input  logic             aeoi,
  input  logic [4:0]       icw2_base,
  input  logic [7:0]       icw3,
  input  logic [2:0]       cas_in,
  output logic [2:0]       cas_out,
  output logic             cas_oe,
  output logic             int_out,
  output logic             isr_set,
  output logic [2:0]       isr_idx,
  output logic             eoi_auto,
  output logic [VEC_W-1:0] data_out,
  output logic             data_oe,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

  state_t     state;
  logic       inta_q;
  logic [2:0] ack_ir;
  logic       sel;
  logic       isr_done;

  logic       fall_c;
  logic       rise_c;
  logic       master_role_c;
  logic       cas_master_c;
  logic       slave_role_c;
  logic [2:0] new_ir_c;
  logic       vec_src_c;

  // INTA edges and role decode
  assign fall_c        = inta_q & ~inta_n;
  assign rise_c        = ~inta_q & inta_n;
  assign master_role_c = sngl | sp_en;
  assign cas_master_c  = ~sngl & sp_en;
  assign slave_role_c  = ~sngl & ~sp_en;
  // No pending request means a spurious acknowledge, answered as IR7
  assign new_ir_c      = int_req ? highest_ir : 3'd7;
  // This device drives the vector unless a cascaded slave owns ack_ir
  assign vec_src_c     = master_role_c ? (sngl | ~icw3[ack_ir]) : sel;

  // Acknowledge sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      inta_q   <= 1'b1;
      ack_ir   <= 3'd0;
      sel      <= 1'b0;
      isr_done <= 1'b0;
      cas_out  <= 3'd0;
      cas_oe   <= 1'b0;
      int_out  <= 1'b0;
      isr_set  <= 1'b0;
      isr_idx  <= 3'd0;
      eoi_auto <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      inta_q   <= inta_n;
      isr_set  <= 1'b0;
      eoi_auto <= 1'b0;
      case (state)
        IDLE: begin
          int_out <= int_req;
          if (fall_c) begin
            state   <= ACK1;
            busy    <= 1'b1;
            int_out <= 1'b0;
            if (master_role_c) begin
              ack_ir <= new_ir_c;
              if (int_req) begin
                isr_set  <= 1'b1;
                isr_idx  <= highest_ir;
                isr_done <= 1'b1;
              end
              // Address the slave that owns this IR for the whole sequence
              if (cas_master_c && icw3[new_ir_c]) begin
                cas_oe  <= 1'b1;
                cas_out <= new_ir_c;
              end
            end
          end
        end
        ACK1: begin
          int_out <= 1'b0;
          if (rise_c) begin
            state <= GAP;
            if (slave_role_c) begin
              sel <= (cas_in == icw3[2:0]);
              if (cas_in == icw3[2:0]) begin
                ack_ir <= new_ir_c;
                if (int_req) begin
                  isr_set  <= 1'b1;
                  isr_idx  <= highest_ir;
                  isr_done <= 1'b1;
                end
              end
            end
          end
        end
        GAP: begin
          int_out <= 1'b0;
          if (fall_c) begin
            state    <= ACK2;
            data_oe  <= vec_src_c;
            data_out <= vec_src_c ? VEC_W'({icw2_base, ack_ir}) : '0;
          end
        end
        ACK2: begin
          int_out <= 1'b0;
          if (rise_c) begin
            state    <= IDLE;
            busy     <= 1'b0;
            data_oe  <= 1'b0;
            data_out <= '0;
            cas_oe   <= 1'b0;
            cas_out  <= 3'd0;
            if (aeoi && isr_done) begin
              eoi_auto <= 1'b1;
              isr_idx  <= ack_ir;
            end
            isr_done <= 1'b0;
            sel      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       inta_n;
  logic       int_req;
  logic [2:0] highest_ir;
  logic       sngl;
  logic       sp_en;
  logic       aeoi;
  logic [4:0] icw2_base;
  logic [7:0] icw3;
  logic [2:0] cas_in;
  logic [2:0] cas_out;
  logic       cas_oe;
  logic       int_out;
  logic       isr_set;
  logic [2:0] isr_idx;
  logic       eoi_auto;
  logic [7:0] data_out;
  logic       data_oe;
  logic       busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned isr_cnt = 0;
  int unsigned eoi_cnt = 0;

  pic_inta_sequencer #(.VEC_W(8)) dut (
    .clk(clk), .rst(rst), .inta_n(inta_n), .int_req(int_req),
    .highest_ir(highest_ir), .sngl(sngl), .sp_en(sp_en), .aeoi(aeoi),
    .icw2_base(icw2_base), .icw3(icw3), .cas_in(cas_in),
    .cas_out(cas_out), .cas_oe(cas_oe), .int_out(int_out),
    .isr_set(isr_set), .isr_idx(isr_idx), .eoi_auto(eoi_auto),
    .data_out(data_out), .data_oe(data_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled at posedge so negedge reads never race them
  always @(posedge clk) begin
    if (isr_set)  isr_cnt <= isr_cnt + 1;
    if (eoi_auto) eoi_cnt <= eoi_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full two-pulse acknowledge, checked against a transaction-level model
  task automatic run_seq(input logic c_sngl, input logic c_sp, input logic c_aeoi,
                         input logic [4:0] base, input logic [7:0] i3,
                         input logic req, input logic [2:0] hir, input logic [2:0] cas);
    logic       m_role, exp_sel, exp_m_isr, exp_s_isr, exp_cas, exp_src, exp_eoi;
    logic [2:0] ack;
    logic [7:0] vec;
    int unsigned c0, e0;
    m_role    = c_sngl | c_sp;
    ack       = req ? hir : 3'd7;
    exp_sel   = !m_role && (cas == i3[2:0]);
    exp_m_isr = m_role && req;
    exp_s_isr = exp_sel && req;
    exp_cas   = !c_sngl && c_sp && i3[ack];
    exp_src   = m_role ? (c_sngl || !i3[ack]) : exp_sel;
    exp_eoi   = c_aeoi && (exp_m_isr || exp_s_isr);
    vec       = {base, ack};

    @(negedge clk);
    sngl = c_sngl; sp_en = c_sp; aeoi = c_aeoi; icw2_base = base; icw3 = i3;
    int_req = req; highest_ir = hir; cas_in = cas; inta_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_int_out", 32'(int_out), 32'(req));
    chk("idle_busy", 32'(busy), 32'd0);
    c0 = isr_cnt; e0 = eoi_cnt;

    inta_n = 1'b0;
    @(negedge clk);
    chk("ack1_busy", 32'(busy), 32'd1);
    chk("ack1_int_out", 32'(int_out), 32'd0);
    chk("ack1_isr_set", 32'(isr_set), 32'(exp_m_isr));
    if (exp_m_isr) chk("ack1_isr_idx", 32'(isr_idx), 32'(hir));
    chk("ack1_cas_oe", 32'(cas_oe), 32'(exp_cas));
    chk("ack1_cas_out", 32'(cas_out), exp_cas ? 32'(ack) : 32'd0);
    // A master froze ack_ir at the first fall; later request changes must not matter
    if (m_role) begin
      int_req = 1'($urandom);
      highest_ir = 3'($urandom);
    end
    @(negedge clk);
    chk("ack1_isr_pulse_end", 32'(isr_set), 32'd0);
    @(negedge clk);

    inta_n = 1'b1;
    @(negedge clk);
    chk("gap_isr_set", 32'(isr_set), 32'(exp_s_isr));
    if (exp_s_isr) chk("gap_isr_idx", 32'(isr_idx), 32'(hir));
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_cas_oe", 32'(cas_oe), 32'(exp_cas));
    repeat (2) @(negedge clk);
    chk("gap_data_oe", 32'(data_oe), 32'd0);

    inta_n = 1'b0;
    @(negedge clk);
    chk("ack2_data_oe", 32'(data_oe), 32'(exp_src));
    chk("ack2_data_out", 32'(data_out), exp_src ? 32'(vec) : 32'd0);
    chk("ack2_cas_oe", 32'(cas_oe), 32'(exp_cas));
    @(negedge clk);
    chk("ack2_data_hold", 32'(data_out), exp_src ? 32'(vec) : 32'd0);
    chk("ack2_int_out", 32'(int_out), 32'd0);

    inta_n = 1'b1;
    @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_data_oe", 32'(data_oe), 32'd0);
    chk("end_cas_oe", 32'(cas_oe), 32'd0);
    chk("end_eoi_auto", 32'(eoi_auto), 32'(exp_eoi));
    if (exp_eoi) chk("end_eoi_idx", 32'(isr_idx), 32'(ack));
    @(negedge clk);
    chk("end_eoi_pulse_end", 32'(eoi_auto), 32'd0);
    chk("isr_pulse_count", isr_cnt - c0, (exp_m_isr || exp_s_isr) ? 32'd1 : 32'd0);
    chk("eoi_pulse_count", eoi_cnt - e0, exp_eoi ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic r_sngl, r_sp;
    logic [7:0] r_i3;
    logic [2:0] r_cas;
    rst = 1'b1; inta_n = 1'b1; int_req = 1'b0; highest_ir = 3'd0;
    sngl = 1'b1; sp_en = 1'b1; aeoi = 1'b0; icw2_base = 5'd0; icw3 = 8'd0; cas_in = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outputs", {cas_out, cas_oe, int_out, isr_set, isr_idx, eoi_auto, data_oe}, 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    rst = 1'b0;

    // Directed cases
    run_seq(1'b1, 1'b0, 1'b0, 5'h08, 8'h00, 1'b1, 3'd3, 3'd0); // single, vector 0x43
    run_seq(1'b0, 1'b1, 1'b0, 5'h08, 8'h04, 1'b1, 3'd2, 3'd0); // master -> slave 2
    run_seq(1'b0, 1'b0, 1'b0, 5'h10, 8'h05, 1'b1, 3'd6, 3'd5); // selected slave, 0x86
    run_seq(1'b0, 1'b0, 1'b0, 5'h10, 8'h05, 1'b1, 3'd6, 3'd4); // unselected slave
    run_seq(1'b1, 1'b0, 1'b1, 5'h08, 8'h00, 1'b0, 3'd2, 3'd0); // spurious, 0x47
    run_seq(1'b1, 1'b1, 1'b1, 5'h08, 8'h00, 1'b1, 3'd1, 3'd0); // AEOI idx 1
    run_seq(1'b0, 1'b1, 1'b1, 5'h08, 8'h04, 1'b1, 3'd2, 3'd0); // master AEOI, slave vector

    // Reset while in GAP
    @(negedge clk);
    sngl = 1'b0; sp_en = 1'b1; icw3 = 8'h04; int_req = 1'b1; highest_ir = 3'd2; aeoi = 1'b1;
    inta_n = 1'b0;
    repeat (2) @(negedge clk);
    inta_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("gap_pre_rst_cas_oe", 32'(cas_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_outputs", {cas_oe, data_oe, int_out, isr_set, eoi_auto}, 32'd0);
    rst = 1'b0;
    run_seq(1'b1, 1'b0, 1'b1, 5'h08, 8'h00, 1'b1, 3'd5, 3'd0);

    // Randomized configurations and requests
    for (int n = 0; n < 30; n++) begin
      r_sngl = 1'($urandom_range(0, 3) == 0);
      r_sp   = 1'($urandom);
      r_i3   = 8'($urandom);
      r_cas  = ($urandom_range(0, 1) == 1) ? r_i3[2:0] : 3'($urandom);
      run_seq(r_sngl, r_sp, 1'($urandom), 5'($urandom), r_i3,
              1'($urandom_range(0, 3) != 0), 3'($urandom), r_cas);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- Clocked controller that sequences the 8259A interrupt-acknowledge (INTA) protocol in 8086 mode (two INTA pulses).
- Sits between the priority resolver / in-service register and the bus and cascade pins.
- In master mode it latches the acknowledged IR, drives the cascade lines to the addressed slave, and supplies the vector.
- In slave mode it decodes the cascade lines against its ID and supplies the vector only when selected.
- It issues the in-service set pulse and, in AEOI mode, the automatic EOI pulse.

Parameters:
- VEC_W, 8, width of the vector byte driven on the data bus

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- inta_n  input  1  interrupt acknowledge, active low, already synchronous to clk
- int_req  input  1  priority resolver has a pending unmasked IR
- highest_ir  input  3  index of the highest-priority pending IR
- sngl  input  1  ICW1 SNGL; 1 means single PIC with no cascade
- sp_en  input  1  1 means master, 0 means slave
- aeoi  input  1  ICW4 AEOI enable
- icw2_base  input  5  ICW2 T7..T3
- icw3  input  8  master: slave-present mask per IR; slave: [2:0] is the slave ID
- cas_in  input  3  cascade lines as sampled from the pins
- cas_out  output  3  cascade value driven in master mode
- cas_oe  output  1  cascade pin output enable
- int_out  output  1  INT request to the CPU or master
- isr_set  output  1  one-cycle pulse: set ISR bit isr_idx
- isr_idx  output  3  IR index for isr_set and eoi_auto
- eoi_auto  output  1  one-cycle pulse: clear ISR bit isr_idx (AEOI)
- data_out  output  VEC_W  vector byte, {icw2_base, ack_ir}
- data_oe  output  1  data bus output enable
- busy  output  1  INTA sequence in progress

Behaviour:
- Reset (synchronous, active-high, one clock): state=IDLE and all outputs 0. Internal inta_q is set to 1, ack_ir to 0, sel to 0, isr_done to 0.
- Edge detect:
  - fall = inta_q & ~inta_n
  - rise = ~inta_q & inta_n
  - inta_q <= inta_n every cycle
- cascaded = ~sngl. master_role = sngl | sp_en.
- FSM: IDLE -> ACK1 -> GAP -> ACK2 -> IDLE. Every transition is registered.
- IDLE:
  - int_out = int_req (registered, 1-cycle latency).
  - On fall: go to ACK1 and clear int_out.
  - Master role: latch ack_ir = int_req ? highest_ir : 7. If int_req=1, pulse isr_set with isr_idx=highest_ir and set isr_done. If int_req=0, the request is spurious: no isr_set and the vector is for IR7.
- ACK1:
  - On rise: go to GAP.
  - Master with cascaded and icw3[ack_ir]=1: cas_out=ack_ir and cas_oe=1 from ACK1 entry until ACK2 exit. Otherwise cas_oe=0 and cas_out=0.
  - Slave (cascaded & ~sp_en): on rise, sel = (cas_in == icw3[2:0]). If sel=1, latch ack_ir = int_req ? highest_ir : 7. If sel=1 and int_req=1, pulse isr_set and set isr_done.
- GAP: on fall, go to ACK2.
- ACK2:
  - data_oe=1 for the whole state when the vector source is this device. The source is this device for: master with icw3[ack_ir]=0, single mode, or selected slave.
  - data_out = {icw2_base, ack_ir} is held stable while data_oe=1. data_oe rises 1 cycle after inta_n falls and drops 1 cycle after inta_n rises.
  - On rise: go to IDLE. If aeoi & isr_done, pulse eoi_auto with isr_idx=ack_ir. Clear isr_done and sel.
- Master AEOI also clears its own ISR bit when a slave supplied the vector.
- busy=1 in every state except IDLE.
- An unselected slave walks the same FSM with data_oe=0 throughout.
- int_out stays 0 from ACK1 through ACK2. It may reassert on the first IDLE cycle if int_req=1.
- Changes to highest_ir or int_req after ACK1 entry are ignored; ack_ir is frozen.
- fall and rise cannot occur in the same cycle.
- An extra INTA pulse in IDLE starts a new sequence.
- rst mid-sequence returns to IDLE immediately and drops data_oe, cas_oe, int_out, and all pulses the same cycle. No eoi_auto is issued.

Test Plan:
- Single master, sngl=1, icw2_base=5'h08, int_req=1, highest_ir=3, two INTA pulses -> isr_set with idx 3 one cycle after the first fall. During the second pulse data_out=8'h43 and data_oe=1. cas_oe stays 0. int_out drops after the first fall.
- Master, sngl=0, sp_en=1, icw3=8'h04, highest_ir=2 -> cas_out=2 and cas_oe=1 from ACK1 entry through ACK2 exit. data_oe stays 0.
- Slave, sp_en=0, icw3[2:0]=5, cas_in=5 at the first rise, highest_ir=6, icw2_base=5'h10 -> isr_set with idx 6 at the first rise. data_out=8'h86 during the second pulse. Repeat with cas_in=4 -> no isr_set and data_oe stays 0.
- Spurious: int_req=0 at the first fall, sngl=1, icw2_base=5'h08 -> no isr_set, data_out=8'h47, no eoi_auto even with aeoi=1.
- AEOI: aeoi=1, highest_ir=1 -> one eoi_auto pulse with idx 1 in the cycle after the second rise, then busy returns to 0.
- Reset asserted during GAP -> the next cycle has busy=0, data_oe=0, cas_oe=0, int_out=0. The next sequence completes normally.
